// File: rtl/button_fifo_port.sv
// Debounced push-button that captures the switch word into a small FIFO on each press.
// The CPU reads the FIFO head at a0=0 and a status word at a0=1.
module button_fifo_port #(
  parameter int DEPTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enter_key,
  input  logic [15:0] switches,
  input  logic        a0,
  input  logic        ack,
  output logic [15:0] data_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic          sync1_q, sync2_q;
  logic          db_q, db_d;
  logic          db_prev_q;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;
  logic          ack_d_q, stat_d_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   mem_q [DEPTH];

  logic rd_evt, stat_evt, empty, full, pop, push, ovf_set;
  logic [7:0]  count8;
  logic [15:0] status_word, head_word;

  // db only follows sync2 after DEBOUNCE_CYCLES consecutive differing cycles.
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    if (sync2_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == DB_LAST) begin
      db_d  = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DW'(1);
    end
  end

  assign press_d = db_q & ~db_prev_q;

  // One pop per CPU access regardless of how long the address is held.
  assign rd_evt   = ack & ~a0 & ~ack_d_q;
  assign stat_evt = ack &  a0 & ~stat_d_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign pop      = rd_evt & ~empty;
  assign push     = press_q & (~full | pop);
  assign ovf_set  = press_q & full & ~pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    // A new overflow on the same edge as a status read stays visible.
    ovf_d = ovf_q;
    if (stat_evt) ovf_d = 1'b0;
    if (ovf_set)  ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      ack_d_q   <= 1'b0;
      stat_d_q  <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      sync1_q   <= enter_key;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      ack_d_q   <= ack & ~a0;
      stat_d_q  <= ack & a0;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= switches;
  end

  assign count8      = 8'(count_q);
  assign status_word = {count8, 5'b00000, ovf_q, full, ~empty};
  assign head_word   = empty ? 16'h0000 : mem_q[rd_ptr_q];
  assign data_out    = a0 ? status_word : head_word;

endmodule

// File: tb/tb_button_fifo_port.sv
// Directed bench for button_fifo_port with DEPTH=4, DEBOUNCE_CYCLES=4.
// Inputs change on the falling edge; data_out is sampled 1ns later.
module tb_button_fifo_port;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enter_key = 1'b0;
  logic [15:0] switches = 16'h0000;
  logic        a0 = 1'b0;
  logic        ack = 1'b0;
  logic [15:0] data_out;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic        key;
    logic [15:0] sw;
    logic        a0v;
    logic        ackv;
    int          cyc;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  button_fifo_port #(
    .DEPTH(4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enter_key(enter_key),
    .switches(switches),
    .a0(a0),
    .ack(ack),
    .data_out(data_out)
  );

  task automatic check(input string name, input logic [15:0] exp);
    total++;
    if (data_out !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, data_out, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic status_is(input string name, input logic [15:0] exp);
    a0  = 1'b1;
    ack = 1'b0;
    #1;
    check(name, exp);
  endtask

  task automatic press(input logic [15:0] sw);
    a0        = 1'b1;
    ack       = 1'b0;
    switches  = sw;
    enter_key = 1'b1;
    cycles(10);
    enter_key = 1'b0;
    cycles(10);
  endtask

  task automatic read_pop(input string name);
    logic [15:0] exp;
    exp = exp_q.pop_front();
    a0  = 1'b0;
    ack = 1'b1;
    #1;
    check(name, exp);
    cycles(1);
    ack = 1'b0;
    cycles(1);
  endtask

  function automatic void add(input logic key, input logic [15:0] sw, input logic a0v,
                              input logic ackv, input int cyc, input logic [15:0] exp);
    vec_t v;
    v.key = key; v.sw = sw; v.a0v = a0v; v.ackv = ackv; v.cyc = cyc; v.exp = exp;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [15:0] st3 [5];
    st3[0] = 16'h0101; st3[1] = 16'h0201; st3[2] = 16'h0301;
    st3[3] = 16'h0403; st3[4] = 16'h0407;

    // Basic capture, release ignored, one pop per access, pop on empty ignored.
    add(1, 16'hA5A5, 1, 0, 7,  16'h0000);
    add(1, 16'hA5A5, 1, 0, 1,  16'h0101);
    add(1, 16'hA5A5, 1, 0, 12, 16'h0101);
    add(0, 16'hA5A5, 1, 0, 10, 16'h0101);
    add(0, 16'h0000, 0, 0, 0,  16'hA5A5);
    add(0, 16'h0000, 0, 1, 1,  16'h0000);
    add(0, 16'h0000, 1, 0, 1,  16'h0000);
    add(0, 16'h0000, 0, 1, 1,  16'h0000);
    add(0, 16'h0000, 0, 0, 1,  16'h0000);
    add(0, 16'h0000, 1, 0, 0,  16'h0000);
    // Glitches of 3 cycles never reach the debounce threshold.
    for (int i = 0; i < 5; i++) begin
      add(1, 16'h0000, 1, 0, 3, 16'h0000);
      add(0, 16'h0000, 1, 0, 5, 16'h0000);
    end
    add(0, 16'h0000, 1, 0, 10, 16'h0000);
    // Five clean presses fill the FIFO and overflow.
    for (int k = 0; k < 5; k++) begin
      add(1, 16'(k + 1), 1, 0, 10, st3[k]);
      add(0, 16'(k + 1), 1, 0, 10, st3[k]);
    end
    add(0, 16'h0000, 1, 1, 1, 16'h0403);
    add(0, 16'h0000, 1, 0, 1, 16'h0403);

    rst_n = 1'b0;
    cycles(2);
    a0 = 1'b1; #1; check("reset_status", 16'h0000);
    a0 = 1'b0; #1; check("reset_data", 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(1);

    for (int i = 0; i < vecs.size(); i++) begin
      enter_key = vecs[i].key;
      switches  = vecs[i].sw;
      a0        = vecs[i].a0v;
      ack       = vecs[i].ackv;
      cycles(vecs[i].cyc);
      #1;
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    for (int k = 1; k <= 4; k++) exp_q.push_back(16'(k));
    for (int k = 1; k <= 4; k++) read_pop($sformatf("fill_read%0d", k));
    status_is("after_drain", 16'h0000);
    cycles(1);

    // Held ack: exactly one pop.
    press(16'h0007);
    press(16'h0008);
    status_is("held_pre", 16'h0201);
    a0  = 1'b0;
    ack = 1'b1;
    cycles(10);
    #1; check("held_head", 16'h0008);
    ack = 1'b0;
    cycles(1);
    status_is("held_status", 16'h0101);
    exp_q.push_back(16'h0008);
    read_pop("held_read");
    status_is("held_empty", 16'h0000);
    cycles(1);

    // Simultaneous push and pop while full.
    for (int k = 1; k <= 4; k++) press(16'(k));
    status_is("simul_full", 16'h0403);
    cycles(1);
    switches  = 16'h0009;
    enter_key = 1'b1;
    a0        = 1'b0;
    ack       = 1'b0;
    cycles(7);
    ack = 1'b1;
    #1; check("simul_head_before", 16'h0001);
    cycles(1);
    #1; check("simul_head_after", 16'h0002);
    ack = 1'b0;
    a0  = 1'b1;
    #1; check("simul_status", 16'h0403);
    cycles(3);
    enter_key = 1'b0;
    cycles(10);
    status_is("simul_status_late", 16'h0403);
    exp_q.push_back(16'h0002); exp_q.push_back(16'h0003);
    exp_q.push_back(16'h0004); exp_q.push_back(16'h0009);
    for (int k = 0; k < 4; k++) read_pop($sformatf("simul_read%0d", k));
    status_is("simul_empty", 16'h0000);
    cycles(1);

    // Async reset mid-debounce with the key held through release.
    press(16'h0011);
    press(16'h0022);
    press(16'h0033);
    status_is("rst_pre", 16'h0301);
    cycles(1);
    switches  = 16'h0066;
    enter_key = 1'b1;
    cycles(4);
    #3;
    rst_n = 1'b0;
    status_is("rst_async_status", 16'h0000);
    a0 = 1'b0; #1; check("rst_async_data", 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(7);
    status_is("rst_edge7", 16'h0000);
    cycles(1);
    status_is("rst_edge8", 16'h0101);
    cycles(20);
    status_is("rst_held", 16'h0101);
    enter_key = 1'b0;
    cycles(10);
    status_is("rst_released", 16'h0101);
    exp_q.push_back(16'h0066);
    read_pop("rst_read");
    status_is("rst_final", 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
